// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared combinational ALU and returns tagged results.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_sel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic            any_valid_s;
    logic            found_s;
    logic [ID_W-1:0] win_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] rr_next_s;
`endif

    // Winner search: first valid requester starting at the search base, wrapping modulo NUM_REQ.
    always_comb begin : win_search
        int idx_v;
        any_valid_s = |req_valid;
        found_s     = 1'b0;
        win_s       = '0;
        idx_v       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            idx_v = k;
`else
            idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
`endif
            if (!found_s && req_valid[idx_v]) begin
                found_s = 1'b1;
                win_s   = ID_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Pointer value following a grant to win_s.
    always_comb begin
        rr_next_s = '0;
        if (win_s == ID_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_s + ID_W'(1);
        end
    end
`endif

    // Grant strobe: only while idle, only to the winner.
    always_comb begin
        req_ready = '0;
        if ((state_r == ST_IDLE) && any_valid_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Control FSM with registered ALU operands and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 4'b0000;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_r  <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        alu_a   <= req_a[int'(win_s)*WIDTH +: WIDTH];
                        alu_b   <= req_b[int'(win_s)*WIDTH +: WIDTH];
                        alu_sel <= req_sel[int'(win_s)*4 +: 4];
                        rsp_id  <= win_s;
                        state_r <= ST_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr_r <= rr_next_s;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_carry <= alu_carry;
                    rsp_valid <= 1'b1;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    // Grant is deliberately withheld in the handshake cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
